apb_requester: RTL

//  APB4 requester (initiator). Turns a valid/ready command stream into APB SETUP/ACCESS

---
 rtl/apb_requester_pkg.sv | 27 ++
 rtl/apb_requester_if.sv | 48 ++++
 rtl/apb_requester_access_timer.sv | 29 ++
 rtl/apb_requester.sv | 104 ++++++++++
 4 files changed

// File: rtl/apb_requester_pkg.sv
// Shared types for the APB4 requester: FSM states and command/response payloads.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_requester_if.sv
// Command, response and APB pin bundle between the requester and its environment.
interface apb_requester_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [STRB_WIDTH-1:0] cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [STRB_WIDTH-1:0] PSTRB;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        input  rsp_ready,
        input  PREADY, PRDATA, PSLVERR,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
        output rsp_ready,
        output PREADY, PRDATA, PSLVERR,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_requester_access_timer.sv
// ACCESS wait-state counter; flags the wait cycle on which the limit is reached.
module apb_access_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_i,
    output logic timeout_c_o
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (count_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // The wait cycle that would bring the count to TIMEOUT_CYCLES is the abort cycle.
    assign timeout_c_o = count_i && (cnt_q == LIMIT);

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: one outstanding SETUP/ACCESS transfer per accepted command.
// Optional ACCESS timeout enabled by defining APB_REQUESTER_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            PCLK,
    input  logic            PRESETn,
    apb_requester_if.master apb
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    if ((TIMEOUT_CYCLES < 1) || ((DATA_WIDTH % 8) != 0)) begin : g_param_check
        $error("apb_requester: bad TIMEOUT_CYCLES or DATA_WIDTH");
    end

    apb_state_e state_q;
    apb_cmd_t   cmd_q;
    apb_rsp_t   rsp_q;
    logic       cmd_ready_q;
    logic       rsp_valid_q;
    logic       psel_q;
    logic       penable_q;
    logic       timeout_c;

`ifdef APB_REQUESTER_TIMEOUT_EN
    apb_access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i      (PCLK),
        .rst_ni     (PRESETn),
        .clear_i    (state_q == SETUP),
        .count_i    ((state_q == ACCESS) && !apb.PREADY),
        .timeout_c_o(timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Transfer FSM; strobes are cleared on completion so PSTRB idles at zero.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (apb.cmd_valid) begin
                        cmd_q.write <= apb.cmd_write;
                        cmd_q.addr  <= APB_ADDR_W'(apb.cmd_addr);
                        cmd_q.wdata <= apb.cmd_write ? APB_DATA_W'(apb.cmd_wdata) : '0;
                        cmd_q.strb  <= apb.cmd_write ? APB_STRB_W'(apb.cmd_strb) : '0;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (apb.PREADY || timeout_c) begin
                        rsp_q.rdata <= (apb.PREADY && !cmd_q.write) ? APB_DATA_W'(apb.PRDATA) : '0;
                        rsp_q.err   <= apb.PREADY ? apb.PSLVERR : 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        cmd_q.strb  <= '0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (apb.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign apb.cmd_ready = cmd_ready_q;
    assign apb.rsp_valid = rsp_valid_q;
    assign apb.rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
    assign apb.rsp_err   = rsp_q.err;
    assign apb.PSEL      = psel_q;
    assign apb.PENABLE   = penable_q;
    assign apb.PWRITE    = cmd_q.write;
    assign apb.PADDR     = ADDR_WIDTH'(cmd_q.addr);
    assign apb.PWDATA    = DATA_WIDTH'(cmd_q.wdata);
    assign apb.PSTRB     = STRB_WIDTH'(cmd_q.strb);

endmodule
